// File: rtl/aes_dec_iter.sv
// Iterative AES inverse cipher: one InvCipher round per clock, using a precomputed key schedule.
// GF(2^8) products go through the shared LN3/EXP3 log tables.
module aes_dec_iter #(
  parameter int unsigned Nk = 4,
  localparam int unsigned Nb = 4,
  localparam int unsigned Nr = Nk + 6,
  localparam int unsigned NWords = Nb * (Nr + 1)
) (
  input  logic                    rst,
  input  logic                    clk,
  input  logic [NWords-1:0][31:0] KExp,
  input  logic [255:0][7:0]       IBox,
  input  logic [255:0][7:0]       EXP3,
  input  logic [255:0][7:0]       LN3,
  input  logic [127:0]            data_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic [127:0]            data_out,
  output logic                    valid_out,
  input  logic                    ready_in
);

  localparam logic [3:0] NrIdx  = 4'(Nr);
  localparam logic [3:0] NrM1   = 4'(Nr - 1);

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] st_q, st_d;

  logic [3:0]   rk_sel;
  logic [5:0]   widx;
  logic [127:0] rk;
  logic [7:0]   s_sr [16];
  logic [7:0]   s_ak [16];
  logic [7:0]   s_mc [16];
  logic [127:0] round_last, round_full;

  // Log/antilog multiply; zero operands short-circuit since LN3[0] is undefined.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    s = {1'b0, LN3[a]} + {1'b0, LN3[b]};
    if (s >= 9'd255) s = s - 9'd255;
    return EXP3[s[7:0]];
  endfunction

  // Round key Nr is whitened in on accept; afterwards the counter selects it.
  always_comb begin
    rk_sel = (state_q == StIdle) ? NrIdx : cnt_q;
    widx   = {rk_sel, 2'b00};
    rk     = '0;
    for (int c = 0; c < 4; c++) rk[127-32*c -: 32] = KExp[widx + 6'(c)];
  end

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        s_sr[r+4*c] = st_q[127-8*(r+4*((c-r)&3)) -: 8];
      end
    end
    for (int i = 0; i < 16; i++) begin
      s_ak[i] = IBox[s_sr[i]] ^ rk[127-8*i -: 8];
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        s_mc[4*c+r] = gf_mul(8'h0e, s_ak[4*c+r])       ^ gf_mul(8'h0b, s_ak[4*c+((r+1)&3)]) ^
                      gf_mul(8'h0d, s_ak[4*c+((r+2)&3)]) ^ gf_mul(8'h09, s_ak[4*c+((r+3)&3)]);
      end
    end
  end

  always_comb begin
    round_last = '0;
    round_full = '0;
    for (int i = 0; i < 16; i++) begin
      round_last[127-8*i -: 8] = s_ak[i];
      round_full[127-8*i -: 8] = s_mc[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    unique case (state_q)
      StIdle: begin
        if (valid_in) begin
          st_d    = data_in ^ rk;
          cnt_d   = NrM1;
          state_d = StRound;
        end
      end
      StRound: begin
        if (cnt_q == 4'd0) begin
          st_d    = round_last;
          state_d = StDone;
        end else begin
          st_d  = round_full;
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        if (ready_in) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
    end
  end

  assign ready_out = (state_q == StIdle);
  assign valid_out = (state_q == StDone);
  assign data_out  = st_q;

endmodule

// File: tb/tb_aes_dec_iter.sv
// Bench for aes_dec_iter: FIPS-197 known answers, backpressure, mid-run reset and back-to-back
// blocks encrypted by a forward-cipher model; results checked through an expected-value queue.
module tb_aes_dec_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [255:0][7:0] ibox, exp3, ln3, sbox;

  logic [43:0][31:0] kexp128;
  logic [127:0] din128, dout128;
  logic vin128, rdyo128, vout128, rdyi128;

  logic [59:0][31:0] kexp256;
  logic [127:0] din256, dout256;
  logic vin256, rdyo256, vout256, rdyi256;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [127:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  aes_dec_iter #(.Nk(4)) u_dut128 (
    .rst(rst), .clk(clk), .KExp(kexp128), .IBox(ibox), .EXP3(exp3), .LN3(ln3),
    .data_in(din128), .valid_in(vin128), .ready_out(rdyo128),
    .data_out(dout128), .valid_out(vout128), .ready_in(rdyi128)
  );

  aes_dec_iter #(.Nk(8)) u_dut256 (
    .rst(rst), .clk(clk), .KExp(kexp256), .IBox(ibox), .EXP3(exp3), .LN3(ln3),
    .data_in(din256), .valid_in(vin256), .ready_out(rdyo256),
    .data_out(dout256), .valid_out(vout256), .ready_in(rdyi256)
  );

  localparam logic [127:0] KeyB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CtB   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PtB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CtC1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PtC   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KeyC3 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CtC3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
  endfunction

  // Tables derived from GF(2^8) arithmetic with generator 3.
  task automatic build_tables();
    logic [7:0] e, x, inv;
    e = 8'h01;
    for (int i = 0; i < 256; i++) begin
      exp3[i] = e;
      if (i < 255) ln3[e] = 8'(i);
      e = e ^ xt(e);
    end
    ln3[0] = 8'h00;
    for (int i = 0; i < 256; i++) begin
      x   = 8'(i);
      inv = (i == 0) ? 8'h00 : exp3[8'((255 - int'(ln3[x])) % 255)];
      sbox[i] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      ibox[sbox[i]] = x;
    end
  endtask

  task automatic key_expand(input logic [255:0] key, input int nk,
                            output logic [59:0][31:0] w);
    logic [31:0] t;
    logic [7:0] rcon;
    int nr;
    nr = nk + 6;
    w = '0;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[6'(i)] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[6'(i - 1)];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[6'(i)] = w[6'(i - nk)] ^ t;
    end
  endtask

  // Forward cipher, used only to mint ciphertexts with known plaintexts.
  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [59:0][31:0] w,
                                           input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a [4];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[6'(i/4)][31-8*(i%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++) s[row+4*c] = t[row+4*((c+row)%4)];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int k = 0; k < 4; k++) a[k] = s[4*c+k];
          s[4*c+0] = xt(a[0]) ^ xt(a[1]) ^ a[1] ^ a[2] ^ a[3];
          s[4*c+1] = a[0] ^ xt(a[1]) ^ xt(a[2]) ^ a[2] ^ a[3];
          s[4*c+2] = a[0] ^ a[1] ^ xt(a[2]) ^ xt(a[3]) ^ a[3];
          s[4*c+3] = xt(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xt(a[3]);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[6'(4*r + i/4)][31-8*(i%4) -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key128(input logic [127:0] key, output logic [59:0][31:0] w);
    key_expand({key, 128'h0}, 4, w);
    kexp128 = w[43:0];
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++; if (rdyo128 !== 1'b1) begin errors++; $display("FAIL reset_ready128 got %b want 1", rdyo128); end
    checks++; if (vout128 !== 1'b0) begin errors++; $display("FAIL reset_valid128 got %b want 0", vout128); end
    checks++; if (dout128 !== '0) begin errors++; $display("FAIL reset_data128 got %h want 0", dout128); end
    checks++; if (rdyo256 !== 1'b1) begin errors++; $display("FAIL reset_ready256 got %b want 1", rdyo256); end
    checks++; if (vout256 !== 1'b0) begin errors++; $display("FAIL reset_valid256 got %b want 0", vout256); end
    checks++; if (dout256 !== '0) begin errors++; $display("FAIL reset_data256 got %h want 0", dout256); end
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  // Accept edge, then valid_out appears after the Nr-th following edge (Nr+1 counting accept).
  task automatic test_kat128(input string name, input logic [127:0] key,
                             input logic [127:0] ct, input logic [127:0] pt);
    logic [59:0][31:0] w;
    int n;
    int busy_bad;
    load_key128(key, w);
    exp_q.push_back(pt);
    din128 = ct; vin128 = 1'b1;
    tick();
    vin128 = 1'b0; din128 = '0;
    n = 0; busy_bad = 0;
    while (n < 40) begin
      if (rdyo128 !== 1'b0) busy_bad++;
      tick(); n++;
      if (vout128 === 1'b1) break;
    end
    checks++; if (n !== 10) begin errors++; $display("FAIL %s_latency got %0d want 10", name, n); end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL %s_ready_busy got %0d high cycles want 0", name, busy_bad); end
    checks++; if (dout128 !== exp_q[0]) begin errors++; $display("FAIL %s_data got %h want %h", name, dout128, exp_q[0]); end
    void'(exp_q.pop_front());
    tick();
  endtask

  task automatic test_aes256();
    logic [59:0][31:0] w;
    int n;
    key_expand(KeyC3, 8, w);
    kexp256 = w;
    exp_q.push_back(PtC);
    din256 = CtC3; vin256 = 1'b1;
    tick();
    vin256 = 1'b0;
    n = 0;
    while (n < 40) begin
      tick(); n++;
      if (vout256 === 1'b1) break;
    end
    checks++; if (n !== 14) begin errors++; $display("FAIL c3_latency got %0d want 14", n); end
    checks++; if (dout256 !== exp_q[0]) begin errors++; $display("FAIL c3_data got %h want %h", dout256, exp_q[0]); end
    void'(exp_q.pop_front());
    tick();
  endtask

  task automatic test_backpressure();
    logic [59:0][31:0] w;
    logic [127:0] hold, pt2;
    int n;
    load_key128(KeyB, w);
    rdyi128 = 1'b0;
    exp_q.push_back(PtB);
    din128 = CtB; vin128 = 1'b1;
    tick();
    vin128 = 1'b0;
    n = 0;
    while (n < 40) begin
      tick(); n++;
      if (vout128 === 1'b1) break;
    end
    checks++; if (n !== 10) begin errors++; $display("FAIL bp_latency got %0d want 10", n); end
    hold = dout128;
    for (int k = 0; k < 5; k++) begin
      vin128 = (k % 2 == 0);
      din128 = {$urandom, $urandom, $urandom, $urandom};
      tick();
      checks++; if (vout128 !== 1'b1) begin errors++; $display("FAIL bp_valid_hold got %b want 1", vout128); end
      checks++; if (dout128 !== hold) begin errors++; $display("FAIL bp_data_hold got %h want %h", dout128, hold); end
    end
    checks++; if (hold !== exp_q[0]) begin errors++; $display("FAIL bp_data got %h want %h", hold, exp_q[0]); end
    void'(exp_q.pop_front());
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(pt2);
    din128 = encrypt(pt2, w, 10); vin128 = 1'b1; rdyi128 = 1'b1;
    tick();
    checks++; if (vout128 !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got %b want 0", vout128); end
    checks++; if (rdyo128 !== 1'b1) begin errors++; $display("FAIL bp_idle_gap got %b want 1", rdyo128); end
    tick();
    checks++; if (rdyo128 !== 1'b0) begin errors++; $display("FAIL bp_next_accept got %b want 0", rdyo128); end
    vin128 = 1'b0;
    n = 0;
    while (n < 40) begin
      tick(); n++;
      if (vout128 === 1'b1) break;
    end
    checks++; if (n !== 10) begin errors++; $display("FAIL bp2_latency got %0d want 10", n); end
    checks++; if (dout128 !== exp_q[0]) begin errors++; $display("FAIL bp2_data got %h want %h", dout128, exp_q[0]); end
    void'(exp_q.pop_front());
    tick();
  endtask

  task automatic test_reset_mid();
    logic [59:0][31:0] w;
    load_key128(KeyB, w);
    din128 = CtB; vin128 = 1'b1;
    tick();
    vin128 = 1'b0;
    for (int k = 0; k < 5; k++) tick();  // round counter now 4
    rst = 1'b0;
    #1;
    checks++; if (vout128 !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", vout128); end
    checks++; if (rdyo128 !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", rdyo128); end
    checks++; if (dout128 !== '0) begin errors++; $display("FAIL rstmid_data got %h want 0", dout128); end
    tick(); tick();
    checks++; if (vout128 !== 1'b0) begin errors++; $display("FAIL rstmid_valid_held got %b want 0", vout128); end
    checks++; if (rdyo128 !== 1'b1) begin errors++; $display("FAIL rstmid_ready_held got %b want 1", rdyo128); end
    rst = 1'b1;
    tick();
    test_kat128("rstmid_b", KeyB, CtB, PtB);
  endtask

  task automatic test_back_to_back();
    logic [59:0][31:0] w;
    logic [127:0] pt [3];
    logic [127:0] ct [3];
    int rise [3];
    int n;
    load_key128(KeyB, w);
    for (int k = 0; k < 3; k++) begin
      pt[k] = {$urandom, $urandom, $urandom, $urandom};
      ct[k] = encrypt(pt[k], w, 10);
    end
    rdyi128 = 1'b1;
    vin128 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din128 = ct[k];
      exp_q.push_back(pt[k]);
      tick();
      n = 0;
      while (n < 40) begin
        tick(); n++;
        if (vout128 === 1'b1) break;
      end
      rise[k] = cyc;
      checks++; if (n !== 10) begin errors++; $display("FAIL b2b_latency%0d got %0d want 10", k, n); end
      checks++; if (dout128 !== exp_q[0]) begin errors++; $display("FAIL b2b_data%0d got %h want %h", k, dout128, exp_q[0]); end
      void'(exp_q.pop_front());
      tick();
    end
    vin128 = 1'b0;
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (rise[k] - rise[k-1] !== 12) begin
        errors++; $display("FAIL b2b_spacing%0d got %0d want 12", k, rise[k] - rise[k-1]);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    kexp128 = '0; kexp256 = '0;
    din128 = '0; vin128 = 1'b0; rdyi128 = 1'b1;
    din256 = '0; vin256 = 1'b0; rdyi256 = 1'b1;
    build_tables();
    test_reset();
    test_kat128("app_b", KeyB, CtB, PtB);
    test_kat128("app_c1", KeyC1, CtC1, PtC);
    test_aes256();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
